// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request, memory bus and load result signals of the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    modport master (
        output req_valid, is_store, funct3, addr, wdata, mem_ready, mem_rdata,
        input  stall, load_data, fault, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
    modport slave (
        input  req_valid, is_store, funct3, addr, wdata, mem_ready, mem_rdata,
        output stall, load_data, fault, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store engine with memory handshake, timeout and load formatting.
module load_store_unit #(
    parameter int unsigned MAX_WAIT = 255
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    state_t      state_q, state_d;
    logic        req_q, req_d, we_q, we_d, flt_q, flt_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d;
    logic [3:0]  be_q, be_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  a;
    logic [2:0]  f3;
    logic        align_ok, f3_ok, legal;
    logic [3:0]  be_n;
    logic [31:0] wd_n, fmt;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    always_comb begin
        a        = bus.addr[1:0];
        f3       = bus.funct3;
        align_ok = (f3[1:0] == 2'b01) ? ~a[0] : (f3[1:0] == 2'b10) ? (a == 2'b00) : 1'b1;
        f3_ok    = bus.is_store ? (f3[2] == 1'b0 && f3[1:0] != 2'b11)
                                : (f3 != 3'b011 && f3[2:1] != 2'b11);
        legal    = f3_ok & align_ok;
        be_n     = (!bus.is_store || f3[1]) ? 4'hF : f3[0] ? (4'b0011 << a) : (4'b0001 << a);
        wd_n     = f3[1] ? bus.wdata : f3[0] ? {2{bus.wdata[15:0]}} : {4{bus.wdata[7:0]}};
        byte_v   = 8'(bus.mem_rdata >> {off_q, 3'b000});
        half_v   = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        fmt      = f3_q[1] ? bus.mem_rdata
                 : f3_q[0] ? {{16{~f3_q[2] & half_v[15]}}, half_v}
                 : {{24{~f3_q[2] & byte_v[7]}}, byte_v};
    end
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        flt_d   = flt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ld_d    = ld_q;
        be_d    = be_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        off_d   = off_q;
        if (state_q == S_IDLE) begin
            if (bus.req_valid && legal) begin
                state_d = S_WAIT;
                req_d   = 1'b1;
                we_d    = bus.is_store;
                addr_d  = {bus.addr[31:2], 2'b00};
                be_d    = be_n;
                wdata_d = wd_n;
                cnt_d   = '0;
                f3_d    = f3;
                off_d   = a;
            end
        end else if (state_q == S_WAIT) begin
            if (bus.mem_ready) begin
                state_d = S_DONE;
                req_d   = 1'b0;
                ld_d    = we_q ? ld_q : fmt;
            end else if (cnt_q == 16'(MAX_WAIT - 1)) begin
                state_d = S_DONE;
                req_d   = 1'b0;
                ld_d    = '0;
                flt_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end else begin
            state_d = S_IDLE;
            flt_d   = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            flt_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ld_q    <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            f3_q    <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            flt_q   <= flt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ld_q    <= ld_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
        end
    end
    // Illegal requests fault immediately in IDLE; timeouts fault from the latched flag in DONE.
    assign bus.stall     = bus.req_valid & legal & (state_q != S_DONE);
    assign bus.fault     = flt_q | ((state_q == S_IDLE) & bus.req_valid & ~legal);
    assign bus.load_data = ld_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for load_store_unit with MAX_WAIT=4.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    load_store_unit_if bus();
    load_store_unit #(.MAX_WAIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ld_model = 32'h0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic drive(input logic v, input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid = v;
        bus.is_store  = st;
        bus.funct3    = f3;
        bus.addr      = a;
        bus.wdata     = wd;
    endtask
    task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int dly, input logic [31:0] ld_exp,
                          input logic [3:0] be_exp, input logic [31:0] wd_exp);
        @(negedge clk);
        drive(1'b1, st, f3, a, wd);
        bus.mem_ready = 1'b0;
        exp_q.push_back(st ? ld_model : ld_exp);
        if (!st) ld_model = ld_exp;
        #1;
        chk("stall_c0", 32'(bus.stall), 32'd1);
        chk("fault_c0", 32'(bus.fault), 32'd0);
        chk("req_c0", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        #1;
        chk("req_c1", 32'(bus.mem_req), 32'd1);
        chk("stall_c1", 32'(bus.stall), 32'd1);
        chk("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
        chk("mem_be", 32'(bus.mem_be), 32'(be_exp));
        chk("mem_we", 32'(bus.mem_we), 32'(st));
        if (st) chk("mem_wdata", bus.mem_wdata, wd_exp);
        repeat (dly) begin
            @(negedge clk);
            #1;
            chk("req_hold", 32'(bus.mem_req), 32'd1);
            chk("addr_hold", bus.mem_addr, {a[31:2], 2'b00});
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rd;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0BAD0BAD;
        #1;
        chk("req_done", 32'(bus.mem_req), 32'd0);
        chk("stall_done", 32'(bus.stall), 32'd0);
        chk("fault_done", 32'(bus.fault), 32'd0);
        chk("load_data", bus.load_data, exp_q.pop_front());
        bus.req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("stall_idle", 32'(bus.stall), 32'd0);
    endtask
    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_fault", 32'(bus.fault), 32'd0);
        chk("rst_be", 32'(bus.mem_be), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        chk("rst_load", bus.load_data, 32'h0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        rst = 1'b0;
        // ready with no request outstanding must be ignored
        @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        #1;
        chk("idle_ready_req", 32'(bus.mem_req), 32'd0);
        chk("idle_ready_load", bus.load_data, ld_model);
        bus.mem_ready = 1'b0;
        access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 4'hF, 32'h0);
        access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 32'hFFFFFF80, 4'hF, 32'h0);
        access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 2, 32'h00000080, 4'hF, 32'h0);
        access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 1, 32'hFFFF80FF, 4'hF, 32'h0);
        access(1'b0, 3'b101, 32'h100, 32'h0, 32'h80FF1234, 0, 32'h00001234, 4'hF, 32'h0);
        access(1'b1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 0, 32'h0, 4'b0010, 32'hA5A5A5A5);
        access(1'b1, 3'b001, 32'h202, 32'h1234BEEF, 32'h0, 1, 32'h0, 4'b1100, 32'hBEEFBEEF);
        access(1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 0, 32'h0, 4'hF, 32'hCAFEF00D);
        // illegal accesses: misaligned lw, load funct3 011, store funct3 100
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
        #1;
        chk("mis_fault", 32'(bus.fault), 32'd1);
        chk("mis_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        #1;
        chk("mis_req", 32'(bus.mem_req), 32'd0);
        chk("mis_load", bus.load_data, ld_model);
        drive(1'b1, 1'b0, 3'b011, 32'h100, 32'h0);
        #1;
        chk("ill_ld_fault", 32'(bus.fault), 32'd1);
        drive(1'b1, 1'b1, 3'b100, 32'h100, 32'h0);
        #1;
        chk("ill_st_fault", 32'(bus.fault), 32'd1);
        @(negedge clk);
        #1;
        chk("ill_req", 32'(bus.mem_req), 32'd0);
        bus.req_valid = 1'b0;
        // timeout
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
        exp_q.push_back(32'h0);
        ld_model = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("to_req", 32'(bus.mem_req), 32'd1);
        end
        @(negedge clk);
        #1;
        chk("to_req_drop", 32'(bus.mem_req), 32'd0);
        chk("to_fault", 32'(bus.fault), 32'd1);
        chk("to_stall", 32'(bus.stall), 32'd0);
        chk("to_load", bus.load_data, exp_q.pop_front());
        bus.req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("to_fault_clr", 32'(bus.fault), 32'd0);
        // reset during the second WAIT cycle
        access(1'b0, 3'b010, 32'h104, 32'h0, 32'h55AA33CC, 0, 32'h55AA33CC, 4'hF, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
        @(negedge clk);
        #1;
        chk("rw_req1", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ld_model = 32'h0;
        #1;
        chk("rw_req", 32'(bus.mem_req), 32'd0);
        chk("rw_addr", bus.mem_addr, 32'h0);
        chk("rw_load", bus.load_data, 32'h0);
        access(1'b0, 3'b010, 32'h108, 32'h0, 32'h13572468, 1, 32'h13572468, 4'hF, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access unit that produces the `Data_from_mem` word consumed by the writeback mux. It accepts a load or store from the execute stage (address = ALU result) and drives a word-addressed data memory with byte enables over a request/ready handshake. It stalls the core while the access is in flight, then returns byte, halfword or word load data with the required sign or zero extension.

## Interface
Parameters:
- `MAX_WAIT`, 255: maximum cycles spent waiting for `mem_ready` before the access is aborted with a fault; 1..65535.

Ports (clock and reset first):
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `req_valid` input 1: current instruction is a load or store; held stable by the core while `stall`=1.
- `is_store` input 1: 1 = store, 0 = load.
- `funct3` input 3: RV32I width/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu).
- `addr` input 32: byte address (ALU result).
- `wdata` input 32: store data (rs2).
- `stall` output 1: freeze PC and pipeline.
- `load_data` output 32: formatted load result, to the writeback `Data_from_mem` input.
- `fault` output 1: misaligned, illegal funct3 or timeout on the current access.
- `mem_req` output 1: memory request.
- `mem_we` output 1: write enable.
- `mem_addr` output 32: word address, `{addr[31:2],2'b00}`.
- `mem_be` output 4: byte enables.
- `mem_wdata` output 32: lane-replicated store data.
- `mem_ready` input 1: memory completes the request this cycle.
- `mem_rdata` input 32: read word, valid when `mem_ready`=1.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If `req_valid` and the access is legal: register `mem_addr`, `mem_we`, `mem_be`, `mem_wdata`, set `mem_req`=1, clear the wait counter, go to WAIT.
  - Illegal: `fault`=1 combinationally, `stall`=0, no request, `load_data` unchanged, stay IDLE.
- WAIT:
  - Hold `mem_req` and all `mem_*` outputs stable.
  - On `mem_ready`: drop `mem_req` next cycle; for loads, register the formatted `mem_rdata` into `load_data`; go to DONE.
  - When the counter reaches `MAX_WAIT` without `mem_ready`: drop `mem_req`, `load_data`=0, latch `fault`=1, go to DONE.
- DONE: `stall`=0 for exactly one cycle while the core retires the instruction; then go to IDLE and clear the latched fault.
- `stall` = `req_valid` & legal & state≠DONE.
- Legality:
  - lw/sw need `addr[1:0]`=00.
  - lh/lhu/sh need `addr[0]`=0.
  - Load funct3 011/110/111 is illegal.
  - Store funct3 other than 000/001/010 is illegal.
- Store lanes:
  - sb: `mem_be`=0001<<`addr[1:0]`, `mem_wdata`={4{wdata[7:0]}}.
  - sh: `mem_be`=0011<<`addr[1:0]`, `mem_wdata`={2{wdata[15:0]}}.
  - sw: `mem_be`=1111, `mem_wdata`=`wdata`.
- Loads: `mem_be`=1111, `mem_we`=0.
- Load formatting:
  - Byte is selected by `addr[1:0]` (lane 0 = bits 7:0); halfword by `addr[1]`.
  - lb/lh sign-extend to 32 bits; lbu/lhu zero-extend; lw passes the word through.
- A store completion leaves `load_data` unchanged.

## Timing
- Reset values:
  - state IDLE.
  - `mem_req`, `mem_we`, `fault` = 0.
  - `mem_be` = 0000.
  - `mem_addr`, `mem_wdata`, `load_data` = 0.
  - `stall` = 0, since no `req_valid` is assumed from the core during reset; `stall` follows the rule above once reset is released.
- Request cycle:
  - Cycle 0: `req_valid` seen in IDLE.
  - Cycle 1: `mem_req` first high.
  - `mem_ready` arriving in cycle k≥1 puts the unit in DONE in cycle k+1, with `load_data` valid and `stall` low.
  - Minimum occupancy is 3 cycles (IDLE, WAIT with immediate ready, DONE).
- `mem_ready` while `mem_req`=0 is ignored.
- Timeout: abort when `mem_ready` is still low after `MAX_WAIT` cycles of `mem_req` high; DONE follows in the next cycle.
- `rst` during WAIT or DONE: the next cycle is IDLE with all reset values; the memory transaction is abandoned.
- `req_valid` dropping mid-WAIT is a core protocol error; the unit still completes the access.

## Test plan
- lw, `addr`=0x100, `mem_rdata`=0xDEADBEEF, `mem_ready` in the first WAIT cycle -> `mem_req` high 1 cycle, `mem_be`=1111, `stall` high 2 cycles, `load_data`=0xDEADBEEF in DONE.
- lb/lbu, `addr`=0x103, `mem_rdata`=0x80FF_1234 -> lb gives 0xFFFFFF80, lbu gives 0x00000080; lh at 0x102 gives 0xFFFF80FF.
- sb, `addr`=0x201, `wdata`=0x000000A5 -> `mem_be`=0010, `mem_wdata`=0xA5A5A5A5, `mem_we`=1, `load_data` unchanged.
- Misaligned lw at 0x102 -> `fault`=1 the same cycle, `stall`=0, `mem_req` never asserted.
- `MAX_WAIT`=4 and `mem_ready` held low -> `mem_req` high 4 cycles, then DONE with `fault`=1 and `load_data`=0.
- `rst` pulsed in the second WAIT cycle -> `mem_req`=0 and state IDLE the following cycle; a fresh lw then completes normally.
